// File: rtl/clk_div_prog_pkg.sv
// clk_div_prog_pkg: shared defaults and ratio helpers for the programmable
// clock divider. Optional feature macro: CLK_DIV_PROG_SYNC_EN (see top).
package clk_div_prog_pkg;

  // Default geometry of the divider bank.
  localparam int NUM_CH_DEF  = 4;
  localparam int CNT_W_DEF   = 8;
  localparam int DEF_DIV_DEF = 2;

  // Smallest ratio that still produces a real high and low phase.
  localparam int MIN_DIV = 2;

  // Ratios below MIN_DIV would give a stuck or degenerate output, so they
  // are promoted to MIN_DIV at capture time.
  function automatic logic [31:0] sanitise_div(input logic [31:0] raw);
    return (raw < 32'(MIN_DIV)) ? 32'(MIN_DIV) : raw;
  endfunction

  // High time of a period of length d; odd ratios spend the extra cycle high.
  // Evaluated on 32 bits so d = 2^CNT_W-1 cannot overflow the +1.
  function automatic logic [31:0] high_time(input logic [31:0] d);
    return (d + 32'd1) >> 1;
  endfunction

endpackage : clk_div_prog_pkg

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control and output bundle of the divider bank.
// The master drives run enable, load strobes and ratio fields; the slave
// (the divider) returns the divided clocks, period ticks and pending flags.
// With CLK_DIV_PROG_SYNC_EN defined the bundle also carries the sync strobe.
interface clk_div_prog_if #(
  parameter int NUM_CH = clk_div_prog_pkg::NUM_CH_DEF,
  parameter int CNT_W  = clk_div_prog_pkg::CNT_W_DEF
);

  logic                    en;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       pend;
`ifdef CLK_DIV_PROG_SYNC_EN
  logic                    sync;

  modport master (
    output en, load, div_val, sync,
    input  clk_out, tick, pend
  );

  modport slave (
    input  en, load, div_val, sync,
    output clk_out, tick, pend
  );
`else
  modport master (
    output en, load, div_val,
    input  clk_out, tick, pend
  );

  modport slave (
    input  en, load, div_val,
    output clk_out, tick, pend
  );
`endif

endinterface : clk_div_prog_if

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel. Holds the period counter, the active
// ratio, a pending ratio with its flag, and the registered clk/tick outputs.
// New ratios are only switched in at a period boundary (or by sync when
// CLK_DIV_PROG_SYNC_EN is defined), so the output never glitches.
module clk_div_chan #(
  parameter int CNT_W   = clk_div_prog_pkg::CNT_W_DEF,
  parameter int DEF_DIV = clk_div_prog_pkg::DEF_DIV_DEF
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
`ifdef CLK_DIV_PROG_SYNC_EN
  input  logic             sync_i,
`endif
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  import clk_div_prog_pkg::*;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dact_q, dact_d;
  logic [CNT_W-1:0] dpend_q, dpend_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic             sync_w;
  logic             wrap;
  logic             apply_now;
  logic [CNT_W-1:0] div_clean;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] d_eff;
  logic [CNT_W-1:0] h_eff;

`ifdef CLK_DIV_PROG_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  assign div_clean = CNT_W'(sanitise_div(32'(div_i)));

  // Last cycle of the current period: the next enabled edge restarts at 0.
  assign wrap      = (cnt_q == dact_q - CNT_W'(1));
  assign cnt_inc   = wrap ? '0 : cnt_q + CNT_W'(1);

  // The pending ratio takes over exactly at the restart edge, and the new
  // ratio already governs the outputs registered on that edge.
  assign apply_now = wrap & pend_q;
  assign d_eff     = apply_now ? dpend_q : dact_q;
  assign h_eff     = CNT_W'(high_time(32'(d_eff)));

  // Next-state: sync overrides counting, counting only while enabled,
  // and a load is captured last so it is never lost to an apply.
  always_comb begin
    cnt_d   = cnt_q;
    dact_d  = dact_q;
    dpend_d = dpend_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;

    if (sync_w) begin
      cnt_d = '0;
      clk_d = 1'b1;
      if (pend_q) begin
        dact_d = dpend_q;
        pend_d = 1'b0;
      end
    end else if (en_i) begin
      cnt_d  = cnt_inc;
      clk_d  = (cnt_inc < h_eff);
      tick_d = (cnt_inc == d_eff - CNT_W'(1));
      if (apply_now) begin
        dact_d = dpend_q;
        pend_d = 1'b0;
      end
    end

    if (load_i) begin
      dpend_d = div_clean;
      pend_d  = 1'b1;
    end
  end

  // Channel state register; reset parks the counter on the last count so the
  // first enabled edge starts a fresh period with clk high.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= CNT_W'(DEF_DIV - 1);
      dact_q  <= CNT_W'(DEF_DIV);
      dpend_q <= CNT_W'(DEF_DIV);
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dact_q  <= dact_d;
      dpend_q <= dpend_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule : clk_div_chan

// File: rtl/clk_div_prog.sv
// clk_div_prog: bank of NUM_CH independent programmable clock dividers, all
// running on clkin. Each channel gives a registered divided clock, a
// clock-enable tick in the last clkin cycle of every period and a flag while
// a newly loaded ratio waits for the next period boundary.
// Optional feature macro: CLK_DIV_PROG_SYNC_EN adds a sync strobe that
// restarts every channel on the same edge and applies pending ratios.
module clk_div_prog #(
  parameter int NUM_CH  = clk_div_prog_pkg::NUM_CH_DEF,
  parameter int CNT_W   = clk_div_prog_pkg::CNT_W_DEF,
  parameter int DEF_DIV = clk_div_prog_pkg::DEF_DIV_DEF
) (
  input  logic          clkin,
  input  logic          rst_n,
  clk_div_prog_if.slave bus
);

  import clk_div_prog_pkg::*;

  logic [NUM_CH-1:0] clk_vec;
  logic [NUM_CH-1:0] tick_vec;
  logic [NUM_CH-1:0] pend_vec;

  // One channel per divided clock, each fed its own ratio field.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      clk_div_chan #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
      ) u_chan (
        .clkin  (clkin),
        .rst_n  (rst_n),
        .en_i   (bus.en),
        .load_i (bus.load[gi]),
        .div_i  (bus.div_val[gi*CNT_W +: CNT_W]),
`ifdef CLK_DIV_PROG_SYNC_EN
        .sync_i (bus.sync),
`endif
        .clk_o  (clk_vec[gi]),
        .tick_o (tick_vec[gi]),
        .pend_o (pend_vec[gi])
      );
    end
  endgenerate

  assign bus.clk_out = clk_vec;
  assign bus.tick    = tick_vec;
  assign bus.pend    = pend_vec;

endmodule : clk_div_prog

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed self-checking bench for clk_div_prog
// (NUM_CH=4, CNT_W=8, DEF_DIV=2). Sync scenario built only with
// CLK_DIV_PROG_SYNC_EN.
module tb_clk_div_prog;

  localparam int NC = 4;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  clk_div_prog_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();

  clk_div_prog #(.NUM_CH(NC), .CNT_W(CW), .DEF_DIV(2)) dut (
    .clkin (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.load    = '0;
    bus.div_val = '0;
`ifdef CLK_DIV_PROG_SYNC_EN
    bus.sync    = 1'b0;
`endif
    step();
    step();
    rst_n  = 1'b1;
    bus.en = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] ec, et;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.load    = '0;
    bus.div_val = '0;
`ifdef CLK_DIV_PROG_SYNC_EN
    bus.sync    = 1'b0;
`endif
    step();
    bus.en = 1'b1;
    step();
    n_cmp++; if (bus.clk_out !== 4'h0) begin n_bad++; $display("FAIL reset_clk: got %b expected %b", bus.clk_out, 4'h0); end
    n_cmp++; if (bus.tick !== 4'h0) begin n_bad++; $display("FAIL reset_tick: got %b expected %b", bus.tick, 4'h0); end
    n_cmp++; if (bus.pend !== 4'h0) begin n_bad++; $display("FAIL reset_pend: got %b expected %b", bus.pend, 4'h0); end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      ec = (k % 2 == 0) ? 4'hF : 4'h0;
      et = (k % 2 == 1) ? 4'hF : 4'h0;
      $display("reset_run k=%0d clk=%b tick=%b", k, bus.clk_out, bus.tick);
      n_cmp++; if (bus.clk_out !== ec) begin n_bad++; $display("FAIL div2_clk k=%0d: got %b expected %b", k, bus.clk_out, ec); end
      n_cmp++; if (bus.tick !== et) begin n_bad++; $display("FAIL div2_tick k=%0d: got %b expected %b", k, bus.tick, et); end
    end
  endtask

  task automatic test_load5();
    logic c5 [10];
    logic t5 [10];
    logic oth;
    logic [3:0] ec, et;
    c5 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t5 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    bus.load         = 4'b0001;
    bus.div_val[7:0] = 8'd5;
    step();
    n_cmp++; if (bus.pend !== 4'b0001) begin n_bad++; $display("FAIL load5_pend: got %b expected %b", bus.pend, 4'b0001); end
    n_cmp++; if (bus.clk_out !== 4'hF) begin n_bad++; $display("FAIL load5_first_clk: got %b expected %b", bus.clk_out, 4'hF); end
    bus.load = '0;
    step();
    n_cmp++; if (bus.pend !== 4'b0001) begin n_bad++; $display("FAIL load5_pend_hold: got %b expected %b", bus.pend, 4'b0001); end
    for (int j = 0; j < 10; j++) begin
      step();
      oth = (j % 2 == 0);
      ec  = {oth, oth, oth, c5[j]};
      et  = {~oth, ~oth, ~oth, t5[j]};
      $display("load5 j=%0d clk=%b tick=%b pend=%b", j, bus.clk_out, bus.tick, bus.pend);
      n_cmp++; if (bus.clk_out !== ec) begin n_bad++; $display("FAIL load5_clk j=%0d: got %b expected %b", j, bus.clk_out, ec); end
      n_cmp++; if (bus.tick !== et) begin n_bad++; $display("FAIL load5_tick j=%0d: got %b expected %b", j, bus.tick, et); end
      n_cmp++; if (bus.pend !== 4'b0000) begin n_bad++; $display("FAIL load5_pend_clr j=%0d: got %b expected %b", j, bus.pend, 4'b0000); end
    end
  endtask

  task automatic test_sanitise();
    logic oth, c2, t2;
    logic [3:0] ec, et;
    do_reset();
    bus.load    = 4'b0111;
    bus.div_val = {8'd0, 8'd255, 8'd1, 8'd0};
    step();
    n_cmp++; if (bus.pend !== 4'b0111) begin n_bad++; $display("FAIL sanit_pend: got %b expected %b", bus.pend, 4'b0111); end
    bus.load = '0;
    step();
    for (int j = 0; j < 256; j++) begin
      step();
      oth = (j % 2 == 0);
      c2  = ((j % 255) < 128);
      t2  = ((j % 255) == 254);
      ec  = {oth, c2, oth, oth};
      et  = {~oth, t2, ~oth, ~oth};
      if (j < 4 || j > 124 && j < 130 || j > 252)
        $display("sanitise j=%0d clk=%b tick=%b", j, bus.clk_out, bus.tick);
      n_cmp++; if (bus.clk_out !== ec) begin n_bad++; $display("FAIL sanit_clk j=%0d: got %b expected %b", j, bus.clk_out, ec); end
      n_cmp++; if (bus.tick !== et) begin n_bad++; $display("FAIL sanit_tick j=%0d: got %b expected %b", j, bus.tick, et); end
      if (j == 0) begin
        n_cmp++; if (bus.pend !== 4'b0000) begin n_bad++; $display("FAIL sanit_pend_clr: got %b expected %b", bus.pend, 4'b0000); end
      end
    end
  endtask

  task automatic test_last_wins();
    logic oth, c1, t1;
    logic [3:0] ec, et;
    do_reset();
    bus.load          = 4'b0010;
    bus.div_val[15:8] = 8'd6;
    step();
    bus.div_val[15:8] = 8'd9;
    step();
    n_cmp++; if (bus.pend !== 4'b0010) begin n_bad++; $display("FAIL last_pend: got %b expected %b", bus.pend, 4'b0010); end
    bus.load = '0;
    for (int j = 0; j < 18; j++) begin
      step();
      oth = (j % 2 == 0);
      c1  = ((j % 9) < 5);
      t1  = ((j % 9) == 8);
      ec  = {oth, oth, c1, oth};
      et  = {~oth, ~oth, t1, ~oth};
      $display("last_wins j=%0d clk=%b tick=%b pend=%b", j, bus.clk_out, bus.tick, bus.pend);
      n_cmp++; if (bus.clk_out !== ec) begin n_bad++; $display("FAIL last_clk j=%0d: got %b expected %b", j, bus.clk_out, ec); end
      n_cmp++; if (bus.tick !== et) begin n_bad++; $display("FAIL last_tick j=%0d: got %b expected %b", j, bus.tick, et); end
      n_cmp++; if (bus.pend !== 4'b0000) begin n_bad++; $display("FAIL last_pend_clr j=%0d: got %b expected %b", j, bus.pend, 4'b0000); end
    end
  endtask

  task automatic test_coincident();
    logic c0 [11];
    logic t0 [11];
    logic oth;
    logic [3:0] ec, et, ep;
    c0 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    t0 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    bus.load         = 4'b0001;
    bus.div_val[7:0] = 8'd5;
    step();
    bus.load = '0;
    step();
    bus.load         = 4'b0001;
    bus.div_val[7:0] = 8'd3;
    for (int j = 0; j < 11; j++) begin
      step();
      bus.load = '0;
      oth = (j % 2 == 0);
      ec  = {oth, oth, oth, c0[j]};
      et  = {~oth, ~oth, ~oth, t0[j]};
      ep  = {3'b000, (j < 5)};
      $display("coincident j=%0d clk=%b tick=%b pend=%b", j, bus.clk_out, bus.tick, bus.pend);
      n_cmp++; if (bus.clk_out !== ec) begin n_bad++; $display("FAIL coin_clk j=%0d: got %b expected %b", j, bus.clk_out, ec); end
      n_cmp++; if (bus.tick !== et) begin n_bad++; $display("FAIL coin_tick j=%0d: got %b expected %b", j, bus.tick, et); end
      n_cmp++; if (bus.pend !== ep) begin n_bad++; $display("FAIL coin_pend j=%0d: got %b expected %b", j, bus.pend, ep); end
    end
  endtask

  task automatic test_enable();
    logic c0 [8];
    logic t0 [8];
    logic c3 [8];
    logic t3 [8];
    logic oth;
    logic [3:0] ec, et, ep;
    c0 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t0 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    c3 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    t3 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    bus.load         = 4'b0001;
    bus.div_val[7:0] = 8'd5;
    step();
    bus.load = '0;
    step();
    step();
    step();
    n_cmp++; if (bus.clk_out !== 4'b0001) begin n_bad++; $display("FAIL en_pre_clk: got %b expected %b", bus.clk_out, 4'b0001); end
    n_cmp++; if (bus.tick !== 4'b1110) begin n_bad++; $display("FAIL en_pre_tick: got %b expected %b", bus.tick, 4'b1110); end
    bus.en = 1'b0;
    for (int f = 0; f < 7; f++) begin
      if (f == 3) begin
        bus.load           = 4'b1000;
        bus.div_val[31:24] = 8'd4;
      end
      step();
      bus.load = '0;
      ep = (f >= 3) ? 4'b1000 : 4'b0000;
      $display("freeze f=%0d clk=%b tick=%b pend=%b", f, bus.clk_out, bus.tick, bus.pend);
      n_cmp++; if (bus.clk_out !== 4'b0001) begin n_bad++; $display("FAIL freeze_clk f=%0d: got %b expected %b", f, bus.clk_out, 4'b0001); end
      n_cmp++; if (bus.tick !== 4'b0000) begin n_bad++; $display("FAIL freeze_tick f=%0d: got %b expected %b", f, bus.tick, 4'b0000); end
      n_cmp++; if (bus.pend !== ep) begin n_bad++; $display("FAIL freeze_pend f=%0d: got %b expected %b", f, bus.pend, ep); end
    end
    bus.en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      step();
      oth = (r % 2 == 0);
      ec  = {c3[r], oth, oth, c0[r]};
      et  = {t3[r], ~oth, ~oth, t0[r]};
      $display("resume r=%0d clk=%b tick=%b pend=%b", r, bus.clk_out, bus.tick, bus.pend);
      n_cmp++; if (bus.clk_out !== ec) begin n_bad++; $display("FAIL resume_clk r=%0d: got %b expected %b", r, bus.clk_out, ec); end
      n_cmp++; if (bus.tick !== et) begin n_bad++; $display("FAIL resume_tick r=%0d: got %b expected %b", r, bus.tick, et); end
      n_cmp++; if (bus.pend !== 4'b0000) begin n_bad++; $display("FAIL resume_pend r=%0d: got %b expected %b", r, bus.pend, 4'b0000); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] ec, et;
    do_reset();
    bus.load           = 4'b0100;
    bus.div_val[23:16] = 8'd7;
    step();
    bus.load = '0;
    n_cmp++; if (bus.pend !== 4'b0100) begin n_bad++; $display("FAIL arst_pre_pend: got %b expected %b", bus.pend, 4'b0100); end
    n_cmp++; if (bus.clk_out !== 4'hF) begin n_bad++; $display("FAIL arst_pre_clk: got %b expected %b", bus.clk_out, 4'hF); end
    #2;
    rst_n = 1'b0;
    #1;
    $display("async_reset clk=%b tick=%b pend=%b", bus.clk_out, bus.tick, bus.pend);
    n_cmp++; if (bus.clk_out !== 4'h0) begin n_bad++; $display("FAIL arst_clk: got %b expected %b", bus.clk_out, 4'h0); end
    n_cmp++; if (bus.tick !== 4'h0) begin n_bad++; $display("FAIL arst_tick: got %b expected %b", bus.tick, 4'h0); end
    n_cmp++; if (bus.pend !== 4'h0) begin n_bad++; $display("FAIL arst_pend: got %b expected %b", bus.pend, 4'h0); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      ec = (k % 2 == 0) ? 4'hF : 4'h0;
      et = (k % 2 == 1) ? 4'hF : 4'h0;
      n_cmp++; if (bus.clk_out !== ec) begin n_bad++; $display("FAIL arst_run_clk k=%0d: got %b expected %b", k, bus.clk_out, ec); end
      n_cmp++; if (bus.tick !== et) begin n_bad++; $display("FAIL arst_run_tick k=%0d: got %b expected %b", k, bus.tick, et); end
    end
  endtask

`ifdef CLK_DIV_PROG_SYNC_EN
  task automatic test_sync();
    int dv [4];
    logic [3:0] ec, et;
    dv = '{3, 4, 5, 7};
    do_reset();
    bus.load    = 4'hF;
    bus.div_val = {8'd7, 8'd5, 8'd4, 8'd3};
    step();
    bus.load = '0;
    n_cmp++; if (bus.pend !== 4'hF) begin n_bad++; $display("FAIL sync_pre_pend: got %b expected %b", bus.pend, 4'hF); end
    bus.sync = 1'b1;
    for (int j = 0; j <= 420; j++) begin
      step();
      bus.sync = 1'b0;
      for (int c = 0; c < 4; c++) begin
        ec[c] = ((j % dv[c]) < ((dv[c] + 1) / 2));
        et[c] = ((j % dv[c]) == (dv[c] - 1));
      end
      if (j < 8 || j > 416)
        $display("sync j=%0d clk=%b tick=%b pend=%b", j, bus.clk_out, bus.tick, bus.pend);
      n_cmp++; if (bus.clk_out !== ec) begin n_bad++; $display("FAIL sync_clk j=%0d: got %b expected %b", j, bus.clk_out, ec); end
      n_cmp++; if (bus.tick !== et) begin n_bad++; $display("FAIL sync_tick j=%0d: got %b expected %b", j, bus.tick, et); end
      if (j == 0) begin
        n_cmp++; if (bus.pend !== 4'h0) begin n_bad++; $display("FAIL sync_pend: got %b expected %b", bus.pend, 4'h0); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load5();
    test_sanitise();
    test_last_wins();
    test_coincident();
    test_enable();
    test_async_reset();
`ifdef CLK_DIV_PROG_SYNC_EN
    test_sync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_clk_div_prog
